multi_tone_generator: RTL and testbench



---
 rtl/multi_tone_generator_pkg.sv | 47 ++++
 rtl/multi_tone_generator_tone_channel.sv | 87 ++++++++
 rtl/multi_tone_generator.sv | 124 ++++++++++++
 tb/tb_multi_tone_generator.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_tone_generator_pkg.sv
// Shared types and sizing helpers for the multi-channel tone generator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: channel FSM state encoding, a constant clog2, and the
// formulas for the full-scale level and the level/counter/accumulator widths.
package multi_tone_generator_pkg;

   typedef enum logic {
      CH_IDLE = 1'b0,
      CH_RUN  = 1'b1
   } ch_state_t;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

   // Full-scale mixed level: every channel high at maximum gain.
   function automatic int full_level(input int num_ch, input int vol_w);
      return num_ch << vol_w;
   endfunction

   // Width able to hold 0..FULL inclusive.
   function automatic int level_width(input int num_ch, input int vol_w);
      return clog2(full_level(num_ch, vol_w) + 1);
   endfunction

   // Width of the PWM frame counter (0..FULL-1).
   function automatic int pwm_cnt_width(input int num_ch, input int vol_w);
      return clog2(full_level(num_ch, vol_w));
   endfunction

   // Sigma-delta accumulator width.
   function automatic int acc_width(input int num_ch, input int vol_w);
      return clog2(full_level(num_ch, vol_w)) + 1;
   endfunction

endpackage

// File: rtl/multi_tone_generator_tone_channel.sv
// Single square-wave tone channel with shadowed half-period.
// Latency: wave starts low on RUN entry, first toggle active_period cycles later.
// Backpressure: none; period changes are absorbed at half-period boundaries.
//
// Ports: clk, rst_n (async active-low), output_enable / ch_enable (run gates),
//        period_in (half-period in clk cycles, 0 = silent), wave (registered).
module tone_channel
   import multi_tone_generator_pkg::*;
#(
   parameter int PERIOD_W = 24
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                output_enable,
   input  logic                ch_enable,
   input  logic [PERIOD_W-1:0] period_in,
   output logic                wave
);

   ch_state_t           state, state_nxt;
   logic [PERIOD_W-1:0] counter, counter_nxt;
   logic [PERIOD_W-1:0] active_period, active_period_nxt;
   logic                wave_nxt;
   logic                run_ok;
   logic                at_boundary;

   assign run_ok      = output_enable & ch_enable;
   // active_period is never 0 while in RUN, so the subtraction cannot wrap there.
   assign at_boundary = (counter == (active_period - PERIOD_W'(1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= CH_IDLE;
         counter       <= '0;
         active_period <= '0;
         wave          <= 1'b0;
      end else begin
         state         <= state_nxt;
         counter       <= counter_nxt;
         active_period <= active_period_nxt;
         wave          <= wave_nxt;
      end
   end

   always_comb begin
      state_nxt         = state;
      counter_nxt       = counter;
      active_period_nxt = active_period;
      wave_nxt          = wave;
      case (state)
         CH_IDLE: begin
            counter_nxt = '0;
            wave_nxt    = 1'b0;
            if (run_ok && (period_in != '0)) begin
               state_nxt         = CH_RUN;
               active_period_nxt = period_in;
            end
         end
         CH_RUN: begin
            if (!run_ok) begin
               // Gate removal silences immediately, no half-period completion.
               state_nxt   = CH_IDLE;
               counter_nxt = '0;
               wave_nxt    = 1'b0;
            end else if (at_boundary) begin
               // Shadow load: the new period only takes effect here.
               counter_nxt       = '0;
               active_period_nxt = period_in;
               if (period_in == '0) begin
                  state_nxt = CH_IDLE;
                  wave_nxt  = 1'b0;
               end else begin
                  wave_nxt = ~wave;
               end
            end else begin
               counter_nxt = counter + PERIOD_W'(1);
            end
         end
         default: begin
            state_nxt   = CH_IDLE;
            counter_nxt = '0;
            wave_nxt    = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/multi_tone_generator.sv
// Multi-channel square-wave tone mixer with volume and 1-bit audio modulator.
// Latency: ch_wave -> mix_level +1 cycle -> frame start -> square_wave_out +1 cycle.
// Backpressure: none; free-running output, input changes apply at boundaries.
//
// Ports: clk, rst_n (async active-low), output_enable (global gate),
//        tone_switch_period (packed half-periods, ch i at [i*PERIOD_W +: PERIOD_W]),
//        ch_enable, volume (gain = volume+1), ch_wave, mix_level (popcount),
//        square_wave_out (PWM, or first-order sigma-delta when
//        MULTI_TONE_SIGMA_DELTA_EN is defined; port list identical in both builds).
module multi_tone_generator
   import multi_tone_generator_pkg::*;
#(
   parameter int NUM_CH   = 2,
   parameter int PERIOD_W = 24,
   parameter int VOL_W    = 3
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         output_enable,
   input  logic [NUM_CH*PERIOD_W-1:0]   tone_switch_period,
   input  logic [NUM_CH-1:0]            ch_enable,
   input  logic [VOL_W-1:0]             volume,
   output logic [NUM_CH-1:0]            ch_wave,
   output logic [clog2(NUM_CH+1)-1:0]   mix_level,
   output logic                         square_wave_out
);

   localparam int FULL    = full_level(NUM_CH, VOL_W);
   localparam int MIX_W   = clog2(NUM_CH + 1);
   localparam int LEVEL_W = level_width(NUM_CH, VOL_W);

   // ---------------------------------------------------------------- channels
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      tone_channel #(
         .PERIOD_W (PERIOD_W)
      ) u_ch (
         .clk           (clk),
         .rst_n         (rst_n),
         .output_enable (output_enable),
         .ch_enable     (ch_enable[i]),
         .period_in     (tone_switch_period[i*PERIOD_W +: PERIOD_W]),
         .wave          (ch_wave[i])
      );
   end

   // ---------------------------------------------------------------- mixer
   logic [MIX_W-1:0]   popcount;
   logic [LEVEL_W-1:0] level;

   always_comb begin
      popcount = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         popcount = popcount + MIX_W'(ch_wave[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mix_level <= '0;
      end else begin
         mix_level <= popcount;
      end
   end

   // mix_level <= NUM_CH and gain <= 2^VOL_W, so the product fits in 0..FULL.
   assign level = LEVEL_W'(mix_level) * (LEVEL_W'(volume) + LEVEL_W'(1));

`ifdef MULTI_TONE_SIGMA_DELTA_EN
   // ---------------------------------------------------------------- sigma-delta
   localparam int ACC_W = acc_width(NUM_CH, VOL_W);
   localparam logic [ACC_W:0] FULL_S = (ACC_W+1)'(FULL);

   logic [ACC_W-1:0] acc;
   logic [ACC_W:0]   acc_sum;

   // One extra bit so acc + level (< 2*FULL) never overflows.
   assign acc_sum = (ACC_W+1)'(acc) + (ACC_W+1)'(level);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc             <= '0;
         square_wave_out <= 1'b0;
      end else if (!output_enable) begin
         acc             <= '0;
         square_wave_out <= 1'b0;
      end else if (acc_sum >= FULL_S) begin
         acc             <= ACC_W'(acc_sum - FULL_S);
         square_wave_out <= 1'b1;
      end else begin
         acc             <= ACC_W'(acc_sum);
         square_wave_out <= 1'b0;
      end
   end
`else
   // ---------------------------------------------------------------- PWM
   localparam int CNT_W = pwm_cnt_width(NUM_CH, VOL_W);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FULL - 1);

   logic [CNT_W-1:0]   pwm_cnt;
   logic [LEVEL_W-1:0] frame_level;
   logic [LEVEL_W-1:0] frame_level_eff;

   // The slot at pwm_cnt==0 already belongs to the new frame, so it compares
   // against the level being latched rather than the previous frame's value.
   assign frame_level_eff = (pwm_cnt == '0) ? level : frame_level;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt         <= '0;
         frame_level     <= '0;
         square_wave_out <= 1'b0;
      end else if (!output_enable) begin
         pwm_cnt         <= '0;
         frame_level     <= '0;
         square_wave_out <= 1'b0;
      end else begin
         pwm_cnt         <= (pwm_cnt == CNT_MAX) ? '0 : pwm_cnt + CNT_W'(1);
         frame_level     <= frame_level_eff;
         square_wave_out <= (LEVEL_W'(pwm_cnt) < frame_level_eff);
      end
   end
`endif

endmodule

// File: tb/tb_multi_tone_generator.sv
// Directed self-checking bench for multi_tone_generator (NUM_CH=2, VOL_W=3, FULL=16).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Tick k denotes the k-th rising edge after stimulus is applied.
module tb_multi_tone_generator;

   localparam int NUM_CH   = 2;
   localparam int PERIOD_W = 24;
   localparam int VOL_W    = 3;

   logic                       clk = 1'b0;
   logic                       rst_n;
   logic                       output_enable;
   logic [NUM_CH*PERIOD_W-1:0] tone_switch_period;
   logic [NUM_CH-1:0]          ch_enable;
   logic [VOL_W-1:0]           volume;
   logic [NUM_CH-1:0]          ch_wave;
   logic [1:0]                 mix_level;
   logic                       square_wave_out;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   multi_tone_generator #(
      .NUM_CH   (NUM_CH),
      .PERIOD_W (PERIOD_W),
      .VOL_W    (VOL_W)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .output_enable      (output_enable),
      .tone_switch_period (tone_switch_period),
      .ch_enable          (ch_enable),
      .volume             (volume),
      .ch_wave            (ch_wave),
      .mix_level          (mix_level),
      .square_wave_out    (square_wave_out)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_period(input int ch, input int val);
      tone_switch_period[ch*PERIOD_W +: PERIOD_W] = PERIOD_W'(val);
   endtask

   task automatic do_reset;
      rst_n              = 1'b0;
      output_enable      = 1'b0;
      ch_enable          = '0;
      tone_switch_period = '0;
      volume             = '0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset;
      rst_n              = 1'b0;
      output_enable      = 1'b0;
      ch_enable          = '0;
      tone_switch_period = '0;
      volume             = '0;
      #3;
      checks++;
      if (ch_wave !== 2'b00) begin
         errors++;
         $display("FAIL reset_ch_wave got=%b exp=00", ch_wave);
      end
      checks++;
      if (mix_level !== 2'd0) begin
         errors++;
         $display("FAIL reset_mix got=%0d exp=0", mix_level);
      end
      checks++;
      if (square_wave_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_out got=%b exp=0", square_wave_out);
      end
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      checks++;
      if ({ch_wave, mix_level, square_wave_out} !== 5'b0) begin
         errors++;
         $display("FAIL reset_idle got=%b exp=00000", {ch_wave, mix_level, square_wave_out});
      end
   endtask

   task automatic test_single_tone;
      logic exp_w0;
      logic prev_w0;
      do_reset();
      output_enable = 1'b1;
      ch_enable     = 2'b01;
      set_period(0, 4);
      prev_w0 = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         // Enter RUN at tick 1, first toggle at tick 5, then every 4 ticks.
         exp_w0 = (k >= 5) && ((((k - 5) / 4) % 2) == 0);
         checks++;
         if (ch_wave !== {1'b0, exp_w0}) begin
            errors++;
            $display("FAIL single_wave k=%0d got=%b exp=%b", k, ch_wave, {1'b0, exp_w0});
         end
         checks++;
         if (mix_level !== {1'b0, prev_w0}) begin
            errors++;
            $display("FAIL single_mix k=%0d got=%0d exp=%0d", k, mix_level, prev_w0);
         end
         prev_w0 = exp_w0;
      end
   endtask

   task automatic test_glitch_free;
      logic exp_w0;
      do_reset();
      output_enable = 1'b1;
      ch_enable     = 2'b01;
      set_period(0, 4);
      for (int k = 1; k <= 30; k++) begin
         tick();
         // Half-period in progress ends at 9 (still 4), later ones are 10 long.
         if (k < 5)       exp_w0 = 1'b0;
         else if (k < 9)  exp_w0 = 1'b1;
         else if (k < 19) exp_w0 = 1'b0;
         else if (k < 29) exp_w0 = 1'b1;
         else             exp_w0 = 1'b0;
         checks++;
         if (ch_wave[0] !== exp_w0) begin
            errors++;
            $display("FAIL glitch_wave k=%0d got=%b exp=%b", k, ch_wave[0], exp_w0);
         end
         if (k == 6) set_period(0, 10);
      end
   endtask

   task automatic test_mix_volume;
      logic exp_o;
      // Both channels in phase, full gain: level 16 from the frame at tick 17.
      do_reset();
      output_enable = 1'b1;
      ch_enable     = 2'b11;
      set_period(0, 8);
      set_period(1, 8);
      volume = 3'd7;
      for (int k = 1; k <= 32; k++) begin
         tick();
         exp_o = (k >= 17);
         checks++;
         if (square_wave_out !== exp_o) begin
            errors++;
            $display("FAIL mix_full_out k=%0d got=%b exp=%b", k, square_wave_out, exp_o);
         end
         if (k == 12) begin
            checks++;
            if (mix_level !== 2'd2) begin
               errors++;
               $display("FAIL mix_both k=%0d got=%0d exp=2", k, mix_level);
            end
         end
         if (k == 20) begin
            checks++;
            if (mix_level !== 2'd0) begin
               errors++;
               $display("FAIL mix_none k=%0d got=%0d exp=0", k, mix_level);
            end
         end
      end
      // One channel, gain 4: level 4 -> first 4 slots of each frame high.
      do_reset();
      output_enable = 1'b1;
      ch_enable     = 2'b01;
      set_period(0, 8);
      volume = 3'd3;
      for (int k = 1; k <= 36; k++) begin
         tick();
         exp_o = ((k >= 17) && (k <= 20)) || ((k >= 33) && (k <= 36));
         checks++;
         if (square_wave_out !== exp_o) begin
            errors++;
            $display("FAIL mix_vol3_out k=%0d got=%b exp=%b", k, square_wave_out, exp_o);
         end
      end
   endtask

   task automatic test_silence;
      logic exp_w0;
      logic exp_o;
      do_reset();
      output_enable = 1'b1;
      ch_enable     = 2'b01;
      set_period(0, 4);
      for (int k = 1; k <= 22; k++) begin
         tick();
         // Period 0 at 6 -> idle at boundary 9; restart at 14 -> rise 19;
         // enable cleared at 20 -> low at 21.
         if (k < 5)       exp_w0 = 1'b0;
         else if (k < 9)  exp_w0 = 1'b1;
         else if (k < 19) exp_w0 = 1'b0;
         else if (k < 21) exp_w0 = 1'b1;
         else             exp_w0 = 1'b0;
         checks++;
         if (ch_wave[0] !== exp_w0) begin
            errors++;
            $display("FAIL silence_wave k=%0d got=%b exp=%b", k, ch_wave[0], exp_w0);
         end
         if (k == 6)  set_period(0, 0);
         if (k == 14) set_period(0, 4);
         if (k == 20) ch_enable = 2'b00;
      end
      // output_enable dropped mid-frame: output low on the next edge.
      do_reset();
      output_enable = 1'b1;
      ch_enable     = 2'b01;
      set_period(0, 8);
      volume = 3'd7;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (k >= 17) begin
            exp_o = (k <= 18);
            checks++;
            if (square_wave_out !== exp_o) begin
               errors++;
               $display("FAIL silence_oe_out k=%0d got=%b exp=%b", k, square_wave_out, exp_o);
            end
         end
         if (k >= 19) begin
            checks++;
            if (ch_wave !== 2'b00) begin
               errors++;
               $display("FAIL silence_oe_wave k=%0d got=%b exp=00", k, ch_wave);
            end
         end
         if (k == 18) output_enable = 1'b0;
      end
   endtask

   task automatic test_reset_mid;
      do_reset();
      output_enable = 1'b1;
      ch_enable     = 2'b01;
      set_period(0, 4);
      for (int k = 1; k <= 17; k++) tick();
      checks++;
      if ({mix_level, square_wave_out} !== 3'b011) begin
         errors++;
         $display("FAIL midrst_pre got=%b exp=011", {mix_level, square_wave_out});
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({ch_wave, mix_level, square_wave_out} !== 5'b0) begin
         errors++;
         $display("FAIL midrst_async got=%b exp=00000", {ch_wave, mix_level, square_wave_out});
      end
      output_enable = 1'b0;
      ch_enable     = 2'b00;
      #2;
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      checks++;
      if ({ch_wave, mix_level, square_wave_out} !== 5'b0) begin
         errors++;
         $display("FAIL midrst_after got=%b exp=00000", {ch_wave, mix_level, square_wave_out});
      end
   endtask

`ifdef MULTI_TONE_SIGMA_DELTA_EN
   task automatic test_sigma_delta;
      logic exp_o;
      // Channels half a period apart keep mix_level at 1 from tick 10 on;
      // gain 4 gives level 4 -> one pulse every 4 cycles, first at tick 14.
      do_reset();
      output_enable = 1'b1;
      ch_enable     = 2'b01;
      set_period(0, 8);
      set_period(1, 8);
      volume = 3'd3;
      for (int k = 1; k <= 42; k++) begin
         tick();
         exp_o = (k >= 14) && (((k - 14) % 4) == 0);
         checks++;
         if (square_wave_out !== exp_o) begin
            errors++;
            $display("FAIL sd_out k=%0d got=%b exp=%b", k, square_wave_out, exp_o);
         end
         if (k == 8) ch_enable = 2'b11;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_tone();
      test_glitch_free();
`ifndef MULTI_TONE_SIGMA_DELTA_EN
      test_mix_volume();
`endif
      test_silence_common();
      test_reset_mid();
`ifdef MULTI_TONE_SIGMA_DELTA_EN
      test_sigma_delta();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Channel-side silence checks apply to both builds; the output-enable part
   // relies on the PWM frame timing, so only the wave checks run otherwise.
   task automatic test_silence_common;
`ifndef MULTI_TONE_SIGMA_DELTA_EN
      test_silence();
`else
      logic exp_w0;
      do_reset();
      output_enable = 1'b1;
      ch_enable     = 2'b01;
      set_period(0, 4);
      for (int k = 1; k <= 22; k++) begin
         tick();
         if (k < 5)       exp_w0 = 1'b0;
         else if (k < 9)  exp_w0 = 1'b1;
         else if (k < 19) exp_w0 = 1'b0;
         else if (k < 21) exp_w0 = 1'b1;
         else             exp_w0 = 1'b0;
         checks++;
         if (ch_wave[0] !== exp_w0) begin
            errors++;
            $display("FAIL silence_wave k=%0d got=%b exp=%b", k, ch_wave[0], exp_w0);
         end
         if (k == 6)  set_period(0, 0);
         if (k == 14) set_period(0, 4);
         if (k == 20) ch_enable = 2'b00;
      end
`endif
   endtask

endmodule
